// File: rtl/mod_n_counter_pkg.sv
// mod_n_counter_pkg
// Shared encodings for the modulo-N counter: counting-mode codes, the
// one-shot FSM states and the width of the mode field.
package mod_n_counter_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

endpackage : mod_n_counter_pkg

// File: rtl/mod_n_counter.sv
// mod_n_counter
// Parametrised modulo-N up/down counter with wrap, saturate and one-shot
// modes. Used as a timebase, prescaler or event counter; stages chain by
// feeding carry_out of one stage into en of the next.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear to 0 (highest priority)
//   load        synchronous parallel load (clamped to MODULUS-1)
//   load_value  value for load
//   en          count enable
//   up_dn       1 = count up, 0 = count down
//   mode        00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//   count       registered count
//   carry_out   combinational: en & at terminal value & wrap mode
//   wrap        registered one-cycle pulse after a wrap transition
//   done        registered; high while the one-shot FSM is in DONE
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | counting normally (all modes)
// ST_DONE | one-shot reached terminal value; count frozen until clear/load
module mod_n_counter
   import mod_n_counter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 16,
   parameter int RESET_VALUE = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic              en,
   input  logic              up_dn,
   input  logic [MODE_W-1:0] mode,
   output logic [WIDTH-1:0]  count,
   output logic              carry_out,
   output logic              wrap,
   output logic              done
);

   if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS must lie in 2..2**WIDTH");
   end
   if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("mod_n_counter: RESET_VALUE must be below MODULUS");
   end

   // Extended-width modulus so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] TERM_UP   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   state_e           state_q, state_d;

   mode_e            mode_eff;
   logic             at_term;
   logic [WIDTH:0]   inc_ext;
   logic [WIDTH-1:0] step_val;
   logic             step_term;

   // Reserved mode decodes as wrap so no encoding leaves the counter undefined.
   always_comb begin
      mode_eff = mode_e'(mode);
      if (mode_eff == MODE_RSVD) begin
         mode_eff = MODE_WRAP;
      end
   end

   assign at_term = up_dn ? (count_q == TERM_UP) : (count_q == '0);

   // One step in the current direction, already wrapped into 0..MODULUS-1.
   always_comb begin
      inc_ext = {1'b0, count_q} + (WIDTH+1)'(1);
      if (up_dn) begin
         step_val = (inc_ext == MOD_EXT) ? '0 : inc_ext[WIDTH-1:0];
      end else begin
         step_val = (count_q == '0) ? TERM_UP : count_q - WIDTH'(1);
      end
      step_term = up_dn ? (step_val == TERM_UP) : (step_val == '0);
   end

   always_comb begin
      count_d = count_q;
      state_d = state_q;
      wrap_d  = 1'b0;
      if (clear) begin
         count_d = '0;
         state_d = ST_RUN;
      end else if (load) begin
         count_d = ({1'b0, load_value} < MOD_EXT) ? load_value : TERM_UP;
         state_d = ST_RUN;
      end else if (en && state_q == ST_RUN) begin
         unique case (mode_eff)
            MODE_SAT: begin
               if (!at_term) begin
                  count_d = step_val;
               end
            end
            MODE_ONESHOT: begin
               // Already sitting on the terminal value also counts as reaching it.
               if (at_term) begin
                  state_d = ST_DONE;
               end else begin
                  count_d = step_val;
                  if (step_term) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: begin
               count_d = step_val;
               wrap_d  = at_term;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= RESET_CNT;
         wrap_q  <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         state_q <= state_d;
      end
   end

   assign count     = count_q;
   assign wrap      = wrap_q;
   assign done      = (state_q == ST_DONE);
   assign carry_out = en & at_term & (mode_eff == MODE_WRAP);

endmodule : mod_n_counter

// File: tb/tb_mod_n_counter.sv
// Testbench for mod_n_counter: a MODULUS=10 instance and a default
// (mod-16) instance share stimulus; each directed vector names which
// instance its hand-computed expectation belongs to.
module tb_mod_n_counter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear, load, en, up_dn;
   logic [3:0] load_value;
   logic [1:0] mode;

   logic [3:0] cnt_a, cnt_b;
   logic       cy_a, cy_b, wr_a, wr_b, dn_a, dn_b;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      bit         dut;
      logic [3:0] cnt;
      logic       wr;
      logic       dn;
      logic       cy;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
      .load_value(load_value), .en(en), .up_dn(up_dn), .mode(mode),
      .count(cnt_a), .carry_out(cy_a), .wrap(wr_a), .done(dn_a)
   );

   mod_n_counter u_dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
      .load_value(load_value), .en(en), .up_dn(up_dn), .mode(mode),
      .count(cnt_b), .carry_out(cy_b), .wrap(wr_b), .done(dn_b)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: one registered response per clock, sampled just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".count"}, e.dut ? cnt_b : cnt_a, e.cnt);
            check({e.name, ".wrap"},  {3'b0, e.dut ? wr_b : wr_a}, {3'b0, e.wr});
            check({e.name, ".done"},  {3'b0, e.dut ? dn_b : dn_a}, {3'b0, e.dn});
            check({e.name, ".carry"}, {3'b0, e.dut ? cy_b : cy_a}, {3'b0, e.cy});
         end
      end
   end

   // Called at a falling edge: apply inputs, queue the response expected
   // after the next rising edge, then advance to the following falling edge.
   task automatic drive(input string name, input bit dut,
                        input logic clr, input logic ld, input logic [3:0] lv,
                        input logic e, input logic ud, input logic [1:0] md,
                        input logic [3:0] ecnt, input logic ewr, input logic edn,
                        input logic ecy);
      exp_t x;
      clear = clr; load = ld; load_value = lv; en = e; up_dn = ud; mode = md;
      x.dut = dut; x.cnt = ecnt; x.wr = ewr; x.dn = edn; x.cy = ecy; x.name = name;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      clear = 0; load = 0; load_value = 0; en = 0; up_dn = 1; mode = 2'b00;
      repeat (2) @(negedge clk);
      check("reset_a.count", cnt_a, 4'd0);
      check("reset_b.count", cnt_b, 4'd0);
      check("reset_a.done", {3'b0, dn_a}, 4'd0);
      reset_n = 1'b1;

      // 1: count to 7, then asynchronous reset between edges
      for (int i = 1; i <= 7; i++)
         drive("t1_up", 0, 0, 0, 0, 1, 1, 2'b00, 4'(i), 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("t1_async.count", cnt_a, 4'd0);
      check("t1_async.wrap", {3'b0, wr_a}, 4'd0);
      check("t1_async.done", {3'b0, dn_a}, 4'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 1; i <= 3; i++)
         drive("t1_after", 0, 0, 0, 0, 1, 1, 2'b00, 4'(i), 0, 0, 0);

      // 2: wrap up MODULUS=10 from 0
      drive("t2_clear", 0, 1, 0, 0, 0, 1, 2'b00, 4'd0, 0, 0, 0);
      for (int i = 1; i <= 8; i++)
         drive("t2_up", 0, 0, 0, 0, 1, 1, 2'b00, 4'(i), 0, 0, 0);
      drive("t2_term", 0, 0, 0, 0, 1, 1, 2'b00, 4'd9, 0, 0, 1);
      drive("t2_wrap", 0, 0, 0, 0, 1, 1, 2'b00, 4'd0, 1, 0, 0);
      drive("t2_post", 0, 0, 0, 0, 1, 1, 2'b00, 4'd1, 0, 0, 0);

      // 2b: default parameters, 15 -> 0
      drive("t2b_load", 1, 0, 1, 4'd14, 0, 1, 2'b00, 4'd14, 0, 0, 0);
      drive("t2b_term", 1, 0, 0, 0, 1, 1, 2'b00, 4'd15, 0, 0, 1);
      drive("t2b_wrap", 1, 0, 0, 0, 1, 1, 2'b00, 4'd0, 1, 0, 0);
      drive("t2b_post", 1, 0, 0, 0, 1, 1, 2'b00, 4'd1, 0, 0, 0);

      // 3: wrap down from 2
      drive("t3_load", 0, 0, 1, 4'd2, 0, 0, 2'b00, 4'd2, 0, 0, 0);
      drive("t3_dn1", 0, 0, 0, 0, 1, 0, 2'b00, 4'd1, 0, 0, 0);
      drive("t3_dn0", 0, 0, 0, 0, 1, 0, 2'b00, 4'd0, 0, 0, 1);
      drive("t3_wrap", 0, 0, 0, 0, 1, 0, 2'b00, 4'd9, 1, 0, 0);
      drive("t3_dn8", 0, 0, 0, 0, 1, 0, 2'b00, 4'd8, 0, 0, 0);

      // 4: saturate up from 7, then down
      drive("t4_load", 0, 0, 1, 4'd7, 0, 1, 2'b01, 4'd7, 0, 0, 0);
      drive("t4_up8", 0, 0, 0, 0, 1, 1, 2'b01, 4'd8, 0, 0, 0);
      drive("t4_up9", 0, 0, 0, 0, 1, 1, 2'b01, 4'd9, 0, 0, 0);
      drive("t4_hold", 0, 0, 0, 0, 1, 1, 2'b01, 4'd9, 0, 0, 0);
      drive("t4_hold", 0, 0, 0, 0, 1, 1, 2'b01, 4'd9, 0, 0, 0);
      drive("t4_dn8", 0, 0, 0, 0, 1, 0, 2'b01, 4'd8, 0, 0, 0);
      drive("t4_dn7", 0, 0, 0, 0, 1, 0, 2'b01, 4'd7, 0, 0, 0);

      // 5: one-shot up from 6
      drive("t5_load", 0, 0, 1, 4'd6, 0, 1, 2'b10, 4'd6, 0, 0, 0);
      drive("t5_7", 0, 0, 0, 0, 1, 1, 2'b10, 4'd7, 0, 0, 0);
      drive("t5_8", 0, 0, 0, 0, 1, 1, 2'b10, 4'd8, 0, 0, 0);
      drive("t5_9", 0, 0, 0, 0, 1, 1, 2'b10, 4'd9, 0, 1, 0);
      drive("t5_hold", 0, 0, 0, 0, 1, 1, 2'b10, 4'd9, 0, 1, 0);
      drive("t5_hold", 0, 0, 0, 0, 1, 1, 2'b10, 4'd9, 0, 1, 0);
      drive("t5_reload", 0, 0, 1, 4'd3, 0, 1, 2'b10, 4'd3, 0, 0, 0);
      drive("t5_4", 0, 0, 0, 0, 1, 1, 2'b10, 4'd4, 0, 0, 0);
      drive("t5_5", 0, 0, 0, 0, 1, 1, 2'b10, 4'd5, 0, 0, 0);

      // 6: priority, clamp, hold
      drive("t6_clr_ld", 0, 1, 1, 4'd5, 1, 1, 2'b00, 4'd0, 0, 0, 0);
      drive("t6_clamp", 0, 0, 1, 4'd12, 0, 1, 2'b00, 4'd9, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         drive("t6_hold", 0, 0, 0, 0, 0, 1, 2'b00, 4'd9, 0, 0, 0);

      // reserved mode behaves as wrap
      drive("t7_rsvd", 0, 0, 0, 0, 1, 1, 2'b11, 4'd0, 1, 0, 0);
      drive("t7_rsvd1", 0, 0, 0, 0, 0, 1, 2'b11, 4'd1 - 4'd1, 0, 0, 0);

      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_mod_n_counter

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
Parametrised modulo-N counter that generalises the team's fixed 4-bit free-running counter. It adds:
- arbitrary width and modulus
- up/down counting, enable, synchronous clear and parallel load
- three counting modes: wrap, saturate, one-shot
- cascade carry and wrap/done status

It is used as a timebase, prescaler and event counter; stages can be chained through carry_out -> en.

Parameters:
WIDTH, 4, counter width in bits
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH (elaboration error otherwise)
RESET_VALUE, 0, count value on reset; must be < MODULUS

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear to 0
load  in  1  synchronous parallel load
load_value  in  WIDTH  value for load
en  in  1  count enable
up_dn  in  1  1 = count up, 0 = count down
mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
count  out  WIDTH  registered count
carry_out  out  1  combinational; en & at_term & (mode is wrap), for cascading
wrap  out  1  registered one-cycle pulse, the cycle after a wrap transition
done  out  1  registered; high while in one-shot DONE state

Behaviour:
- Reset: reset_n low asynchronously forces the following, independent of clk:
  - count = RESET_VALUE
  - wrap = 0
  - done = 0
  - FSM = RUN
- Reset deassertion takes effect at the next edge. Reset mid-count discards all state.
- Terminal value (at_term): count == MODULUS-1 when up_dn=1; count == 0 when up_dn=0. Purely combinational.
- Per-edge priority: clear > load > en. With en=0 and no clear/load, everything holds and wrap returns to 0.
- clear: count <= 0, FSM <= RUN, wrap <= 0, done <= 0.
- load:
  - count <= load_value if load_value < MODULUS, else MODULUS-1 (clamp).
  - FSM <= RUN, done <= 0, wrap <= 0.
- en, wrap mode:
  - up: count+1, or 0 from MODULUS-1.
  - down: count-1, or MODULUS-1 from 0.
  - A wrap transition sets wrap=1 for exactly the next cycle.
- en, saturate mode: step toward the terminal value, then hold it. wrap never asserts.
- en, one-shot mode:
  - FSM RUN: step as in saturate. The edge that reaches the terminal value moves FSM to DONE, so done=1 the cycle count shows the terminal value.
  - FSM DONE: en is ignored and count holds.
  - DONE exits only via clear or load.
- mode or up_dn changes: take effect on the next counting edge. A mode change while in DONE does not leave DONE unless a clear/load occurs.
- Arithmetic: next-value computed in WIDTH+1 bits before comparison, so MODULUS = 2**WIDTH wraps correctly (15 -> 0 at defaults, identical to the legacy mod-16 counter).
- Latency: count, wrap and done are registered with 1-cycle latency from inputs. carry_out is 0-latency and combinational on count/en/mode/up_dn.
- No X propagation: all registers are reset, and reserved mode is decoded as wrap.

Decomposition:
- Package mod_n_counter_pkg:
  - mode encodings MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD
  - FSM state encodings ST_RUN, ST_DONE
  - width constant for mode (2)
- Single flat module. No sub-module is natural; the next-value logic is one always block, plus the FSM and the wrap register.

Test Plan:
1. WIDTH=4, MODULUS=10, en=1, up: count at 7, pull reset_n low between edges -> count=0, wrap=0, done=0 immediately; after release, counts 1,2,... from the next edge.
2. Wrap up, MODULUS=10, from 0:
   - count reaches 9 at edge 9 with carry_out=1 that cycle.
   - Edge 10 gives count=0 with wrap=1 for one cycle only.
   - Default params: 15 -> 0 with wrap=1.
3. Wrap down: load 2, up_dn=0 -> 2,1,0,9,8; carry_out=1 while count=0; wrap=1 the cycle count=9.
4. Saturate, up, load 7 -> 8,9,9,9; carry_out=0 and wrap=0 throughout. Switch up_dn=0 -> 8,7.
5. One-shot, up, load 6:
   - Sequence 7,8,9 with done=1 from the cycle count=9.
   - Further en holds 9/done=1.
   - load 3 -> count=3, done=0, then 4,5.
6. Priority/clamp:
   - clear and load(5) same edge -> count=0.
   - load_value=12 with MODULUS=10 -> count=9.
   - en=0 for 5 cycles -> count stable, wrap=0.
